// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, counter debounce, press/release strobes, hold-to-repeat.
// Latency btn_in -> level/press is 2 + DEBOUNCE_CYCLES cycles; no backpressure, every output is a strobe or level.
module btn_conditioner #(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_,
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] step,
  output logic            any_press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD      = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP      = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic [N_CH-1:0] meta;
  logic [N_CH-1:0] sync;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic          lvl_q, press_q, rel_q, rpt_q;
    logic          differ, flip;
    rpt_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rpt_d;

    assign differ = sync[i] ^ lvl_q;
    assign flip   = differ && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
        db_cnt  <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= flip & ~lvl_q;
        rel_q   <= flip & lvl_q;
        if (!differ || flip) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
        if (flip) begin
          lvl_q <= ~lvl_q;
        end
      end
    end

    // Release and a disabled repeat_en both abort the FSM without a final strobe.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rpt_d   = 1'b0;
      if ((flip && lvl_q) || !repeat_en[i]) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (flip && !lvl_q) begin
              state_d = DELAY;
              rcnt_d  = R_ONE;
            end
          end
          DELAY: begin
            if (rcnt_q == RD) begin
              rpt_d   = 1'b1;
              state_d = REPEAT;
              rcnt_d  = R_ONE;
            end else begin
              rcnt_d = rcnt_q + R_ONE;
            end
          end
          REPEAT: begin
            if (rcnt_q == RP) begin
              rpt_d  = 1'b1;
              rcnt_d = R_ONE;
            end else begin
              rcnt_d = rcnt_q + R_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        rpt_q   <= rpt_d;
      end
    end

    assign level[i]    = lvl_q;
    assign press[i]    = press_q;
    assign release_[i] = rel_q;
    assign rpt[i]      = rpt_q;
  end

  assign step      = press | rpt;
  assign any_press = |press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed plus randomized bench for btn_conditioner against a run-length / age based reference model.
module tb_btn_conditioner;
  localparam int NC = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset_ = 1'b1;
  logic [NC-1:0] btn_in = '0;
  logic [NC-1:0] repeat_en = '0;
  logic [NC-1:0] level, press, release_, rpt, step;
  logic          any_press;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_CH(NC), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_(reset_), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press(press), .release_(release_), .rpt(rpt),
    .step(step), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: pin history, disagreement run length, and age since press.
  logic [NC-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rpt;
  int            m_run [NC];
  int            m_age [NC];
  bit            m_armed [NC];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0; m_age[i] = 0; m_armed[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NC-1:0] np, nr, nrpt;
    np = '0; nr = '0; nrpt = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_run[i] = 0;
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) np[i] = 1'b1;
          else          nr[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      if (nr[i] || !repeat_en[i]) begin
        m_armed[i] = 0;
      end else if (np[i]) begin
        m_armed[i] = 1;
        m_age[i]   = 0;
      end else if (m_armed[i]) begin
        m_age[i]++;
        if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
          nrpt[i] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
    m_press = np; m_rel = nr; m_rpt = nrpt;
  endtask

  task automatic chk(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("level", level, m_lvl);
    chk("press", press, m_press);
    chk("release", release_, m_rel);
    chk("rpt", rpt, m_rpt);
    chk("step", step, m_press | m_rpt);
    chk("any_press", {{(NC-1){1'b0}}, any_press}, {{(NC-1){1'b0}}, |m_press});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_) model_reset();
    else        model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();
    run(3);
    chk("reset_level", level, 3'b000);
    chk("reset_step", step, 3'b000);
    reset_ = 1'b0;
    run(2);

    // Clean press/release on ch0, no repeat
    btn_in[0] = 1'b1;
    run(5);
    chk("press_not_early", level, 3'b000);
    run(1);
    chk("press_lat", press, 3'b001);
    chk("level_lat", level, 3'b001);
    run(1);
    chk("press_width", press, 3'b000);
    run(13);
    btn_in[0] = 1'b0;
    run(6);
    chk("release_lat", release_, 3'b001);
    chk("rpt_off", rpt, 3'b000);
    run(4);

    // Glitch rejection on ch1: 3 cycles rejected, 4 accepted
    btn_in[1] = 1'b1;
    run(3);
    btn_in[1] = 1'b0;
    run(10);
    chk("glitch_level", level, 3'b000);
    btn_in[1] = 1'b1;
    run(4);
    btn_in[1] = 1'b0;
    run(2);
    chk("glitch4_press", press, 3'b010);
    run(10);

    // Auto-repeat on ch2
    repeat_en = 3'b111;
    btn_in[2] = 1'b1;
    run(6);
    chk("rep_press_step", step, 3'b100);
    run(10);
    chk("rep_first", rpt, 3'b100);
    run(3);
    chk("rep_second", rpt, 3'b100);
    run(3);
    chk("rep_third", step, 3'b100);
    btn_in[2] = 1'b0;
    run(20);

    // Disable repeat mid-hold, re-enable without a new press
    btn_in[2] = 1'b1;
    run(6);
    run(10);
    chk("dis_first", rpt, 3'b100);
    run(1);
    repeat_en[2] = 1'b0;
    run(2);
    chk("dis_no_rpt", rpt, 3'b000);
    run(1);
    repeat_en[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("reen_no_rpt", rpt, 3'b000);
    end
    btn_in[2] = 1'b0;
    run(10);

    // Simultaneous press
    repeat_en = 3'b000;
    btn_in = 3'b111;
    run(6);
    chk("sim_press", press, 3'b111);
    chk("sim_any", {2'b00, any_press}, 3'b001);
    run(1);
    chk("sim_any_width", {2'b00, any_press}, 3'b000);
    btn_in = 3'b000;
    run(10);

    // Asynchronous reset during DELAY on ch0
    repeat_en = 3'b001;
    btn_in[0] = 1'b1;
    run(6);
    run(4);
    #2;
    reset_ = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_level", level, 3'b000);
    tick();
    reset_ = 1'b0;
    run(5);
    chk("rst_no_early", press, 3'b000);
    run(1);
    chk("rst_press", press, 3'b001);
    run(10);
    chk("rst_rpt", rpt, 3'b001);
    btn_in = '0;
    run(10);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) btn_in[$urandom_range(0, NC - 1)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) repeat_en = NC'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        reset_ = 1'b1;
        run(2);
        reset_ = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
